// File: rtl/id_exe_pipe_reg.sv
// ID/EX pipeline register with stall hold, deferred flush under stall and bubble insertion.
// Optional performance counters are enabled by defining ID_EXE_PERF_CNT_EN.
module id_exe_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rd_addr,
    input  logic [3:0]        id_alu_op,
    input  logic [7:0]        id_ctrl,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs1_data,
    output logic [DATA_W-1:0] ex_rs2_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rd_addr,
    output logic [3:0]        ex_alu_op,
    output logic [7:0]        ex_ctrl,
    output logic              ex_valid,
    output logic              flush_pend,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        PEND  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   bubble;
    logic   load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (stall) begin
            if (flush) begin
                state_nxt = PEND;
            end
        end else if (state == PEND || flush) begin
            state_nxt = EMPTY;
        end else begin
            state_nxt = id_valid ? FULL : EMPTY;
        end
    end

    // A recorded flush takes effect on the first non-stalled edge, ahead of any load.
    always_comb begin
        bubble = 1'b0;
        load   = 1'b0;
        if (!stall) begin
            bubble = (state == PEND) || flush;
            load   = !bubble;
        end
    end

    assign flush_pend = (state == PEND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rd_addr  <= '0;
            ex_alu_op   <= '0;
            ex_ctrl     <= '0;
            ex_valid    <= 1'b0;
        end else if (bubble) begin
            ex_rd_addr <= '0;
            ex_alu_op  <= '0;
            ex_ctrl    <= '0;
            ex_valid   <= 1'b0;
        end else if (load) begin
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rd_addr  <= id_rd_addr;
            ex_alu_op   <= id_alu_op;
            ex_ctrl     <= id_valid ? id_ctrl : '0;
            ex_valid    <= id_valid;
        end
    end

`ifdef ID_EXE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (bubble && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign flush_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Self-checking bench for id_exe_pipe_reg: directed scenarios followed by random traffic
// compared against a rule-level reference model.
module tb_id_exe_pipe_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          stall;
    logic          id_valid;
    logic [DW-1:0] id_pc;
    logic [DW-1:0] id_rs1_data;
    logic [DW-1:0] id_rs2_data;
    logic [DW-1:0] id_imm;
    logic [4:0]    id_rd_addr;
    logic [3:0]    id_alu_op;
    logic [7:0]    id_ctrl;
    logic [DW-1:0] ex_pc;
    logic [DW-1:0] ex_rs1_data;
    logic [DW-1:0] ex_rs2_data;
    logic [DW-1:0] ex_imm;
    logic [4:0]    ex_rd_addr;
    logic [3:0]    ex_alu_op;
    logic [7:0]    ex_ctrl;
    logic          ex_valid;
    logic          flush_pend;
    logic [CW-1:0] flush_cnt;
    logic [CW-1:0] stall_cnt;

    id_exe_pipe_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rd_addr(id_rd_addr), .id_alu_op(id_alu_op), .id_ctrl(id_ctrl),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rd_addr(ex_rd_addr), .ex_alu_op(ex_alu_op), .ex_ctrl(ex_ctrl),
        .ex_valid(ex_valid), .flush_pend(flush_pend),
        .flush_cnt(flush_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what EX should hold, whether a flush is owed, event counts.
    logic          m_valid;
    logic [DW-1:0] m_pc, m_rs1, m_rs2, m_imm;
    logic [4:0]    m_rd;
    logic [3:0]    m_alu;
    logic [7:0]    m_ctrl;
    bit            m_owed;
    int            m_bubbles;
    int            m_stalls;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_pc = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0;
        m_rd = '0; m_alu = '0; m_ctrl = '0; m_owed = 1'b0;
        m_bubbles = 0; m_stalls = 0;
    endtask

    function automatic logic [CW-1:0] cnt_exp(input int events);
`ifdef ID_EXE_PERF_CNT_EN
        int lim = (1 << CW) - 1;
        return CW'((events > lim) ? lim : events);
`else
        return '0;
`endif
    endfunction

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (stall) begin
            m_stalls++;
            if (flush) m_owed = 1'b1;
        end else if (m_owed || flush) begin
            m_valid = 1'b0; m_ctrl = '0; m_alu = '0; m_rd = '0;
            m_owed = 1'b0;
            m_bubbles++;
        end else begin
            m_valid = id_valid;
            m_pc = id_pc; m_rs1 = id_rs1_data; m_rs2 = id_rs2_data; m_imm = id_imm;
            m_rd = id_rd_addr; m_alu = id_alu_op;
            m_ctrl = id_valid ? id_ctrl : 8'h00;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ex_valid"}, 64'(ex_valid), 64'(m_valid));
        chk({tag, ".ex_pc"}, 64'(ex_pc), 64'(m_pc));
        chk({tag, ".ex_rs1"}, 64'(ex_rs1_data), 64'(m_rs1));
        chk({tag, ".ex_rs2"}, 64'(ex_rs2_data), 64'(m_rs2));
        chk({tag, ".ex_imm"}, 64'(ex_imm), 64'(m_imm));
        chk({tag, ".ex_rd"}, 64'(ex_rd_addr), 64'(m_rd));
        chk({tag, ".ex_alu"}, 64'(ex_alu_op), 64'(m_alu));
        chk({tag, ".ex_ctrl"}, 64'(ex_ctrl), 64'(m_ctrl));
        chk({tag, ".flush_pend"}, 64'(flush_pend), 64'(m_owed));
        chk({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(cnt_exp(m_bubbles)));
        chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(cnt_exp(m_stalls)));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic rand_id();
        id_valid    = ($urandom_range(0, 9) < 7);
        id_pc       = $urandom;
        id_rs1_data = $urandom;
        id_rs2_data = $urandom;
        id_imm      = $urandom;
        id_rd_addr  = 5'($urandom);
        id_alu_op   = 4'($urandom);
        id_ctrl     = 8'($urandom);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        rand_id();
        model_reset();
        #1;
        check_all("reset");
        tick("reset_edge");
        rst = 1'b0;

        // Directed load
        id_valid = 1'b1; id_pc = 32'h0000_0100; id_ctrl = 8'h41;
        tick("load");
        chk("load.pc_const", 64'(ex_pc), 64'h100);
        chk("load.ctrl_const", 64'(ex_ctrl), 64'h41);

        // Stall hold for three cycles with a new PC presented
        stall = 1'b1; id_pc = 32'h0000_0104;
        for (int i = 0; i < 3; i++) tick("stall_hold");
        chk("stall_hold.pc_const", 64'(ex_pc), 64'h100);

        // Flush recorded under stall, applied on the first non-stall edge
        flush = 1'b1;
        tick("flush_stall0");
        flush = 1'b0;
        tick("flush_stall1");
        tick("flush_stall2");
        chk("flush_stall.pend_const", 64'(flush_pend), 64'h1);
        stall = 1'b0; id_valid = 1'b1; id_pc = 32'h0000_0200; id_ctrl = 8'h3F;
        tick("pend_bubble");
        chk("pend_bubble.valid_const", 64'(ex_valid), 64'h0);
        chk("pend_bubble.pc_not_loaded", 64'(ex_pc), 64'h100);
        tick("after_pend_load");

        // Plain flush from FULL, then reload
        rand_id(); id_valid = 1'b1; flush = 1'b1;
        tick("plain_flush");
        flush = 1'b0;
        tick("plain_reload");

        // Asynchronous reset while a flush is pending
        stall = 1'b1; flush = 1'b1;
        tick("to_pend");
        #3 rst = 1'b1;
        #1 model_reset();
        check_all("async_rst");
        #2 rst = 1'b0;
        stall = 1'b0; flush = 1'b0; rand_id(); id_valid = 1'b1;
        tick("post_rst_load");

        // Counter saturation
        stall = 1'b1;
        for (int i = 0; i < 20; i++) tick("sat");
        chk("sat.stall_cnt", 64'(stall_cnt), 64'(cnt_exp(20 + m_stalls - 20)));
        stall = 1'b0;
        tick("sat_release");

        // Random traffic with occasional mid-cycle resets
        for (int i = 0; i < 400; i++) begin
            rand_id();
            stall = ($urandom_range(0, 9) < 3);
            flush = ($urandom_range(0, 9) < 2);
            if ($urandom_range(0, 99) == 0) begin
                #3 rst = 1'b1;
                #1 model_reset();
                check_all("rand_async_rst");
                #1 rst = 1'b0;
            end
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
